dpc_frame_gate_ctrl: RTL and testbench

Frame-aligned run/pause controller between the DPC kernel master stream and the block output.
- Replaces combinational go-gating, which can cut a frame mid-line, with a gate that opens only on start-of-frame (tuser) and closes only after the last beat of a frame.
- Shadows bad_point_num so the kernel sees a value that is constant for a whole frame.
- Checks frame geometry and reports status.

---
 rtl/dpc_frame_gate_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dpc_frame_gate_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpc_frame_gate_ctrl.sv
// -----------------------------------------------------------------------------
// dpc_frame_gate_ctrl
//
// Frame-aligned run/pause gate between the DPC kernel master stream and the
// block output. The gate opens only on a start-of-frame beat (tuser) and
// closes only after the last beat of a frame, so a frame is never cut
// mid-line. The bad-point count is shadowed on every SOF transfer so the
// kernel sees a value that is constant for a whole frame. Frame geometry is
// tracked with column/row counters and mismatches raise a sticky error flag.
//
// Ports:
//   axis_aclk          stream clock
//   axis_aresetn       asynchronous active-low reset
//   go                 run request level (already synchronous to axis_aclk)
//   bad_point_num_in   configured bad-point count
//   bad_point_num_act  frame-stable shadow of bad_point_num_in, to kernel
//   s_axis_*           kernel output stream (slave side of this block)
//   m_axis_*           block output stream (zero-latency pass-through)
//   frame_active       high while a frame is being passed (RUN)
//   frame_cnt          completed frames passed, wraps 65535 -> 0
//   err_geom           sticky geometry error
//   clr_err            synchronous clear of err_geom (a same-cycle set wins)
// -----------------------------------------------------------------------------
module dpc_frame_gate_ctrl #(
  parameter int ROW              = 512,
  parameter int COL              = 640,
  parameter int AXIS_TDATA_WIDTH = 14,
  parameter int CFG_WIDTH        = 8
) (
  input  logic                        axis_aclk,
  input  logic                        axis_aresetn,
  input  logic                        go,
  input  logic [CFG_WIDTH-1:0]        bad_point_num_in,
  output logic [CFG_WIDTH-1:0]        bad_point_num_act,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tuser,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        frame_active,
  output logic [15:0]                 frame_cnt,
  output logic                        err_geom,
  input  logic                        clr_err
);

  // Counters keep at least one bit so degenerate 1-pixel geometries still build.
  localparam int COL_W = (COL > 1) ? $clog2(COL) : 1;
  localparam int ROW_W = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t               state_reg;
  logic [COL_W-1:0]     col_reg;
  logic [ROW_W-1:0]     row_reg;
  logic [15:0]          frame_cnt_reg;
  logic                 err_geom_reg;
  logic                 frame_active_reg;
  logic [CFG_WIDTH-1:0] bad_point_num_act_reg;

  logic                 pass_en;
  logic                 xfer;
  logic                 beat_xfer;
  logic [COL_W-1:0]     beat_col;
  logic [ROW_W-1:0]     beat_row;
  logic                 at_col_last;
  logic                 line_end;
  logic                 frame_end;
  logic                 restart_err;
  logic                 geom_bad;

  // ---------------------------------------------------------------------------
  // Handshake gating. In WAIT_SOF non-SOF beats are swallowed (ready high,
  // nothing forwarded) so the kernel drains up to the next frame boundary.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state_reg)
      WAIT_SOF: begin
        if (s_axis_tuser) begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
        end else begin
          s_axis_tready = 1'b1;
        end
      end
      RUN: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
      end
      default: begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
      end
    endcase
  end

  assign pass_en      = (state_reg != IDLE);
  assign m_axis_tdata = pass_en ? s_axis_tdata : '0;
  assign m_axis_tuser = pass_en & s_axis_tuser;
  assign m_axis_tlast = pass_en & s_axis_tlast;

  // ---------------------------------------------------------------------------
  // Geometry of the beat being transferred. An SOF beat always sits at (0,0),
  // whether it opens a frame from WAIT_SOF or restarts one inside RUN, so the
  // same advance logic serves both states.
  // ---------------------------------------------------------------------------
  assign xfer        = s_axis_tvalid & s_axis_tready;
  assign beat_xfer   = ((state_reg == RUN) & xfer) |
                       ((state_reg == WAIT_SOF) & xfer & s_axis_tuser);
  assign beat_col    = s_axis_tuser ? '0 : col_reg;
  assign beat_row    = s_axis_tuser ? '0 : row_reg;
  assign at_col_last = (beat_col == COL_LAST);
  // Either a tlast or a full line ends the line; a mismatch is only flagged.
  assign line_end    = s_axis_tlast | at_col_last;
  assign frame_end   = line_end & (beat_row == ROW_LAST);
  assign restart_err = s_axis_tuser & (state_reg == RUN) &
                       ((col_reg != '0) | (row_reg != '0));
  assign geom_bad    = (s_axis_tlast != at_col_last) | restart_err;

  // ---------------------------------------------------------------------------
  // FSM, position counters and status registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_reg             <= IDLE;
      col_reg               <= '0;
      row_reg               <= '0;
      frame_cnt_reg         <= '0;
      frame_active_reg      <= 1'b0;
      bad_point_num_act_reg <= '0;
    end else begin
      if (beat_xfer) begin
        if (s_axis_tuser) begin
          bad_point_num_act_reg <= bad_point_num_in;
        end
        if (frame_end) begin
          // Next frame's SOF may pass the very next cycle when go is held.
          col_reg          <= '0;
          row_reg          <= '0;
          frame_cnt_reg    <= frame_cnt_reg + 16'd1;
          state_reg        <= go ? WAIT_SOF : IDLE;
          frame_active_reg <= 1'b0;
        end else if (line_end) begin
          col_reg          <= '0;
          row_reg          <= beat_row + ROW_W'(1);
          state_reg        <= RUN;
          frame_active_reg <= 1'b1;
        end else begin
          col_reg          <= beat_col + COL_W'(1);
          row_reg          <= beat_row;
          state_reg        <= RUN;
          frame_active_reg <= 1'b1;
        end
      end else begin
        case (state_reg)
          IDLE: begin
            if (go) begin
              state_reg <= WAIT_SOF;
            end
          end
          WAIT_SOF: begin
            if (!go) begin
              state_reg <= IDLE;
            end
          end
          RUN: begin
            // go is deliberately ignored until the frame completes.
            state_reg <= RUN;
          end
          default: begin
            state_reg        <= IDLE;
            frame_active_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky error: a set in the same cycle as clr_err takes priority.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      err_geom_reg <= 1'b0;
    end else if (beat_xfer && geom_bad) begin
      err_geom_reg <= 1'b1;
    end else if (clr_err) begin
      err_geom_reg <= 1'b0;
    end
  end

  assign frame_active      = frame_active_reg;
  assign frame_cnt         = frame_cnt_reg;
  assign err_geom          = err_geom_reg;
  assign bad_point_num_act = bad_point_num_act_reg;

endmodule

// File: tb/tb_dpc_frame_gate_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for dpc_frame_gate_ctrl (ROW=4, COL=8).
// A kernel emulator drives frames with optional geometry faults, a frame-level
// reference model predicts every output each cycle, and a few hand-computed
// literal checks pin the model at the end of each scenario.
// -----------------------------------------------------------------------------
module tb_dpc_frame_gate_ctrl;

  localparam int ROW = 4;
  localparam int COL = 8;
  localparam int DW  = 14;
  localparam int CW  = 8;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_RUN  = 2;

  logic          axis_aclk = 1'b0;
  logic          axis_aresetn = 1'b0;
  logic          go = 1'b0;
  logic [CW-1:0] bad_point_num_in = '0;
  logic [CW-1:0] bad_point_num_act;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          frame_active;
  logic [15:0]   frame_cnt;
  logic          err_geom;
  logic          clr_err = 1'b0;

  always #5 axis_aclk = ~axis_aclk;

  dpc_frame_gate_ctrl #(
    .ROW(ROW), .COL(COL), .AXIS_TDATA_WIDTH(DW), .CFG_WIDTH(CW)
  ) dut (
    .axis_aclk(axis_aclk),
    .axis_aresetn(axis_aresetn),
    .go(go),
    .bad_point_num_in(bad_point_num_in),
    .bad_point_num_act(bad_point_num_act),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast),
    .frame_active(frame_active),
    .frame_cnt(frame_cnt),
    .err_geom(err_geom),
    .clr_err(clr_err)
  );

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Observation counters, cleared by the stimulus between scenarios.
  int n_out = 0;
  int n_disc = 0;
  bit got_first = 0;
  bit first_user = 0;

  // ---------------------------------------------------------------------------
  // Reference model: frame position as plain integers plus the gate mode.
  // ---------------------------------------------------------------------------
  int          m_mode = M_IDLE;
  int          m_r = 0;
  int          m_c = 0;
  int          m_cnt = 0;
  bit          m_err = 0;
  bit          m_set = 0;
  logic [CW-1:0] m_bpn = '0;

  task automatic model_beat();
    if (s_axis_tuser) begin
      if (m_mode == M_RUN && (m_r != 0 || m_c != 0)) m_set = 1;
      m_r = 0;
      m_c = 0;
      m_bpn = bad_point_num_in;
    end
    if (s_axis_tlast != (m_c == COL - 1)) m_set = 1;
    if (s_axis_tlast || m_c == COL - 1) begin
      if (m_r == ROW - 1) begin
        m_cnt = (m_cnt + 1) % 65536;
        m_r = 0;
        m_c = 0;
        m_mode = go ? M_WAIT : M_IDLE;
      end else begin
        m_r = m_r + 1;
        m_c = 0;
        m_mode = M_RUN;
      end
    end else begin
      m_c = m_c + 1;
      m_mode = M_RUN;
    end
  endtask

  always @(negedge axis_aclk) begin : compare_proc
    bit e_rdy;
    bit e_val;
    bit xf;
    #2;
    if (!axis_aresetn) begin
      m_mode = M_IDLE; m_r = 0; m_c = 0; m_cnt = 0; m_err = 0; m_bpn = '0;
    end
    if (m_mode == M_IDLE) begin
      e_rdy = 0; e_val = 0;
    end else if (m_mode == M_WAIT && !s_axis_tuser) begin
      e_rdy = 1; e_val = 0;
    end else begin
      e_rdy = m_axis_tready; e_val = s_axis_tvalid;
    end
    chk("s_tready", 32'(s_axis_tready), 32'(e_rdy));
    chk("m_tvalid", 32'(m_axis_tvalid), 32'(e_val));
    chk("frame_active", 32'(frame_active), 32'(m_mode == M_RUN));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("err_geom", 32'(err_geom), 32'(m_err));
    chk("bpn_act", 32'(bad_point_num_act), 32'(m_bpn));
    if (e_val) begin
      chk("m_tdata", 32'(m_axis_tdata), 32'(s_axis_tdata));
      chk("m_tuser", 32'(m_axis_tuser), 32'(s_axis_tuser));
      chk("m_tlast", 32'(m_axis_tlast), 32'(s_axis_tlast));
    end
    if (m_mode == M_IDLE) begin
      chk("idle_m_tdata", 32'(m_axis_tdata), 32'd0);
      chk("idle_m_tuser", 32'(m_axis_tuser), 32'd0);
      chk("idle_m_tlast", 32'(m_axis_tlast), 32'd0);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      n_out++;
      if (!got_first) begin
        got_first = 1;
        first_user = m_axis_tuser;
      end
    end
    if (s_axis_tvalid && s_axis_tready && !m_axis_tvalid) n_disc++;
    if (axis_aresetn) begin
      xf = s_axis_tvalid && e_rdy;
      m_set = 0;
      case (m_mode)
        M_IDLE: if (go) m_mode = M_WAIT;
        M_WAIT: begin
          if (xf && s_axis_tuser) model_beat();
          else if (!go) m_mode = M_IDLE;
        end
        default: if (xf) model_beat();
      endcase
      if (m_set) m_err = 1;
      else if (clr_err) m_err = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Kernel emulator: holds each beat until it is accepted, with optional
  // early-tlast and spurious-tuser injection.
  // ---------------------------------------------------------------------------
  int          k_r = 0;
  int          k_c = 0;
  int          k_left = 0;
  bit          k_valid = 0;
  logic [DW-1:0] k_data = '0;
  int          k_vpct = 100;
  int          m_rpct = 100;
  bit          inj_last = 0;
  int          inj_last_col = 0;
  bit          inj_user = 0;
  int          inj_user_row = 0;

  // One clock: called at a negedge, returns at the next negedge.
  task automatic cycle();
    bit xf;
    if (!k_valid && k_left > 0 && int'($urandom_range(99)) < k_vpct) begin
      k_valid = 1;
      k_data = DW'($urandom);
    end
    s_axis_tvalid = k_valid;
    s_axis_tdata  = k_data;
    s_axis_tuser  = (k_r == 0 && k_c == 0) || (inj_user && k_r == inj_user_row && k_c == 0);
    s_axis_tlast  = (k_c == COL - 1) || (inj_last && k_r == 0 && k_c == inj_last_col);
    m_axis_tready = (int'($urandom_range(99)) < m_rpct);
    #3;
    xf = s_axis_tvalid && s_axis_tready;
    @(negedge axis_aclk);
    if (xf) begin
      k_valid = 0;
      k_left--;
      if (s_axis_tuser && !(k_r == 0 && k_c == 0)) begin
        inj_user = 0; k_r = 0; k_c = 1;
      end else if (s_axis_tlast && k_c != COL - 1) begin
        inj_last = 0; k_c = 0; k_r = k_r + 1;
      end else begin
        k_c++;
        if (k_c == COL) begin
          k_c = 0;
          k_r = (k_r + 1) % ROW;
        end
      end
    end
  endtask

  task automatic run_until_left(input int target, input int maxc);
    int n = 0;
    while (k_left > target && n < maxc) begin
      cycle();
      n++;
    end
    chk("timeout_left", 32'(k_left > target), 32'd0);
  endtask

  task automatic run_until_done(input int maxc);
    int n = 0;
    while ((k_left > 0 || k_valid) && n < maxc) begin
      cycle();
      n++;
    end
    chk("timeout_done", 32'(k_left > 0 || k_valid), 32'd0);
  endtask

  task automatic clear_obs();
    n_out = 0; n_disc = 0; got_first = 0; first_user = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    @(negedge axis_aclk);
    repeat (3) cycle();
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    axis_aresetn = 1'b1;

    // 1: three clean frames, go raised before the first frame.
    go = 1'b1;
    bad_point_num_in = 8'd3;
    clear_obs();
    k_left = 96;
    run_until_done(400);
    chk("t1_beats_out", 32'(n_out), 32'd96);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("t1_err_geom", 32'(err_geom), 32'd0);
    chk("t1_bpn_act", 32'(bad_point_num_act), 32'd3);

    // 2: go raised while the kernel sits mid-frame at row 2 col 3.
    go = 1'b0;
    repeat (2) cycle();
    k_r = 2; k_c = 3; k_left = 13 + 32;
    clear_obs();
    repeat (3) cycle();
    chk("t2_stalled", 32'(k_left), 32'd45);
    go = 1'b1;
    run_until_done(400);
    chk("t2_discarded", 32'(n_disc), 32'd13);
    chk("t2_first_tuser", 32'(first_user), 32'd1);
    chk("t2_beats_out", 32'(n_out), 32'd32);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd4);

    // 3: go dropped at row 1 col 0; the frame still completes.
    clear_obs();
    k_left = 32;
    run_until_left(24, 200);
    go = 1'b0;
    run_until_done(200);
    chk("t3_beats_out", 32'(n_out), 32'd32);
    chk("t3_tready_after", 32'(s_axis_tready), 32'd0);
    chk("t3_frame_active", 32'(frame_active), 32'd0);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd5);

    // 4: bad_point_num_in changes 5 -> 9 mid-frame.
    bad_point_num_in = 8'd5;
    go = 1'b1;
    k_left = 64;
    run_until_left(54, 200);
    bad_point_num_in = 8'd9;
    chk("t4_bpn_mid", 32'(bad_point_num_act), 32'd5);
    run_until_left(32, 200);
    chk("t4_bpn_end", 32'(bad_point_num_act), 32'd5);
    run_until_left(31, 200);
    chk("t4_bpn_next", 32'(bad_point_num_act), 32'd9);
    run_until_done(200);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd7);

    // 5: 30% downstream backpressure and a bursty kernel.
    m_rpct = 70;
    k_vpct = 80;
    clear_obs();
    k_left = 96;
    run_until_done(2000);
    chk("t5_beats_out", 32'(n_out), 32'd96);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd10);
    m_rpct = 100;
    k_vpct = 100;

    // 6: early tlast at col 5, then a spurious tuser at row 2.
    inj_last = 1; inj_last_col = 5;
    inj_user = 1; inj_user_row = 2;
    k_left = 6 + 8 + 32;
    run_until_left(32, 200);
    chk("t6_err_early", 32'(err_geom), 32'd1);
    chk("t6_cnt_before", 32'(frame_cnt), 32'd10);
    run_until_done(200);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd11);
    chk("t6_err_geom", 32'(err_geom), 32'd1);
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    chk("t6_err_cleared", 32'(err_geom), 32'd0);

    // 7: reset asserted mid-frame, then a clean frame.
    k_left = 32;
    run_until_left(22, 200);
    axis_aresetn = 1'b0;
    #1;
    chk("t7_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("t7_rst_tready", 32'(s_axis_tready), 32'd0);
    chk("t7_rst_active", 32'(frame_active), 32'd0);
    chk("t7_rst_bpn", 32'(bad_point_num_act), 32'd0);
    k_valid = 0; k_r = 0; k_c = 0; k_left = 0;
    repeat (2) cycle();
    axis_aresetn = 1'b1;
    k_left = 32;
    run_until_done(200);
    chk("t7_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t7_bpn", 32'(bad_point_num_act), 32'd9);
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
